// File: rtl/lcd_pkg.sv
// lcd_pkg: shared LCD types, field positions, command and colour constants.
// Imported by lcd_spi_writer and the picture/command generators.
package lcd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_GAP
    } wr_state_t;

    localparam int DC_BIT   = 8;
    localparam int BYTE_MSB = 7;

    localparam logic [7:0] CMD_CASET = 8'h2A;
    localparam logic [7:0] CMD_RASET = 8'h2B;
    localparam logic [7:0] CMD_RAMWR = 8'h2C;

    localparam logic [15:0] RGB565_BLACK = 16'h0000;
    localparam logic [15:0] RGB565_WHITE = 16'hFFFF;
    localparam logic [15:0] RGB565_RED   = 16'hF800;
    localparam logic [15:0] RGB565_GREEN = 16'h07E0;
    localparam logic [15:0] RGB565_BLUE  = 16'h001F;

    function automatic logic [7:0] byte_of(input logic [8:0] w);
        return w[BYTE_MSB:0];
    endfunction

endpackage

// File: rtl/lcd_spi_writer_if.sv
// lcd_spi_writer_if: word handshake between LCD generators and the SPI writer.
// master = generator side, slave = lcd_spi_writer side.
interface lcd_spi_writer_if;
    logic       en_write;
    logic [8:0] data;
    logic       wr_done;
    logic       busy;

    modport master (
        output en_write, data,
        input  wr_done, busy
    );

    modport slave (
        input  en_write, data,
        output wr_done, busy
    );
endinterface

// File: rtl/lcd_sclk_gen.sv
// lcd_sclk_gen: SPI mode-0 clock for one 8-bit word (16 toggles).
// Emits falling-edge shift strobes and a registered end-of-word pulse.
module lcd_sclk_gen #(
    parameter int CLK_DIV = 2
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic run,
    output logic sclk,
    output logic fall,
    output logic last_fall
);
    localparam int HW = $clog2(CLK_DIV) + 1;
    localparam logic [HW-1:0] HMAX = HW'(CLK_DIV - 1);
    localparam logic [4:0] NTOG = 5'd16;

    logic [HW-1:0] hcnt;
    logic [4:0]    tcnt;
    logic          tick;

    assign tick = run && (tcnt != NTOG) && (hcnt == HMAX);
    // the 8th falling edge closes the word rather than shifting
    assign fall = tick && sclk && (tcnt != NTOG - 5'd1);

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            hcnt      <= '0;
            tcnt      <= '0;
            sclk      <= 1'b0;
            last_fall <= 1'b0;
        end else if (!run) begin
            hcnt      <= '0;
            tcnt      <= '0;
            sclk      <= 1'b0;
            last_fall <= 1'b0;
        end else begin
            last_fall <= 1'b0;
            if (tcnt != NTOG) begin
                if (hcnt == HMAX) begin
                    hcnt      <= '0;
                    sclk      <= ~sclk;
                    tcnt      <= tcnt + 5'd1;
                    last_fall <= (tcnt == NTOG - 5'd1);
                end else begin
                    hcnt <= hcnt + HW'(1);
                end
            end
        end
    end
endmodule

// File: rtl/lcd_spi_writer.sv
// lcd_spi_writer: shifts 9-bit {dc, byte} words out on 4-wire SPI, mode 0.
// Optional word counter output wr_cnt when LCD_SPI_WR_STAT_EN is defined.
module lcd_spi_writer
    import lcd_pkg::*;
#(
    parameter int CLK_DIV    = 2,
    parameter int GAP_CYCLES = 2
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    lcd_spi_writer_if.slave wr,
    output logic lcd_sclk,
    output logic lcd_mosi,
    output logic lcd_dc,
`ifdef LCD_SPI_WR_STAT_EN
    output logic [19:0] wr_cnt,
`endif
    output logic lcd_cs_n
);
    localparam int GW = $clog2(GAP_CYCLES) + 1;
    localparam logic [GW-1:0] GMAX = GW'(GAP_CYCLES - 1);

    wr_state_t     state, state_nxt;
    logic [7:0]    sreg;
    logic [GW-1:0] gcnt;
    logic          fall;
    logic          last_fall;

    // MOSI is the MSB of the shift register, so it only moves on a shift
    assign lcd_mosi = sreg[7];

    lcd_sclk_gen #(.CLK_DIV(CLK_DIV)) u_sclk (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .run       (state == ST_SHIFT),
        .sclk      (lcd_sclk),
        .fall      (fall),
        .last_fall (last_fall)
    );

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) state <= ST_IDLE;
        else            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE:  if (wr.en_write) state_nxt = ST_SHIFT;
            ST_SHIFT: if (last_fall)   state_nxt = ST_GAP;
            ST_GAP:   if (gcnt == GMAX) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            sreg       <= '0;
            gcnt       <= '0;
            lcd_dc     <= 1'b0;
            lcd_cs_n   <= 1'b1;
            wr.wr_done <= 1'b0;
            wr.busy    <= 1'b0;
        end else begin
            wr.wr_done <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (wr.en_write) begin
                        sreg     <= byte_of(wr.data);
                        lcd_dc   <= wr.data[DC_BIT];
                        lcd_cs_n <= 1'b0;
                        wr.busy  <= 1'b1;
                    end else begin
                        lcd_cs_n <= 1'b1;
                    end
                end
                ST_SHIFT: begin
                    if (fall) sreg <= {sreg[6:0], 1'b0};
                    if (last_fall) begin
                        wr.wr_done <= 1'b1;
                        gcnt       <= '0;
                    end
                end
                ST_GAP: begin
                    if (gcnt == GMAX) wr.busy <= 1'b0;
                    else              gcnt    <= gcnt + GW'(1);
                end
                default: ;
            endcase
        end
    end

`ifdef LCD_SPI_WR_STAT_EN
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n)
            wr_cnt <= '0;
        else if (wr.wr_done && wr_cnt != 20'hFFFFF)
            wr_cnt <= wr_cnt + 20'd1;
    end
`endif
endmodule
